// File: rtl/ccff_loader.sv
// ccff_loader: configuration-chain loader for the fpga_top fabric.
// Takes bitstream bytes over a valid/ready link, shifts them LSB first onto
// ccff_head with a divided prog_clk for exactly CHAIN_LEN bits, keeps the
// fabric in reset until a load completes, and XOR-folds ccff_tail samples.
module ccff_loader #(
  parameter int CHAIN_LEN = 1024,
  parameter int CLK_DIV   = 4,
  parameter int TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       prog_clk,
  output logic       ccff_head,
  input  logic       ccff_tail,
  output logic       fabric_reset,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       tail_parity
);

  localparam int BIT_W = $clog2(CHAIN_LEN + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD     = 3'd1;
  localparam logic [2:0] ST_SHIFT_LO = 3'd2;
  localparam logic [2:0] ST_SHIFT_HI = 3'd3;
  localparam logic [2:0] ST_FINISH   = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;
  localparam logic [2:0] ST_ERROR    = 3'd6;

  // Readback parity accumulation step.
  function automatic logic parity_fold(input logic acc, input logic bit_in);
    parity_fold = acc ^ bit_in;
  endfunction

  logic [2:0]       state_r,   state_s;
  logic [7:0]       shreg_r,   shreg_s;
  logic [BIT_W-1:0] bit_cnt_r, bit_cnt_s;
  logic [2:0]       byte_bit_r, byte_bit_s;
  logic [DIV_W-1:0] div_cnt_r, div_cnt_s;
  logic [TMO_W-1:0] tmo_cnt_r, tmo_cnt_s;
  logic             fin_r,     fin_s;
  logic             parity_s;

  logic byte_ready_r, prog_clk_r, ccff_head_r, fabric_reset_r;
  logic busy_r, done_r, error_r, tail_parity_r;

  logic div_last_s;
  assign div_last_s = (div_cnt_r == DIV_W'(CLK_DIV - 1));

  // Next-state and datapath update; abort overrides everything else.
  always_comb begin
    state_s    = state_r;
    shreg_s    = shreg_r;
    bit_cnt_s  = bit_cnt_r;
    byte_bit_s = byte_bit_r;
    div_cnt_s  = div_cnt_r;
    tmo_cnt_s  = tmo_cnt_r;
    fin_s      = fin_r;
    parity_s   = tail_parity_r;
    if (abort) begin
      state_s   = ST_IDLE;
      bit_cnt_s = BIT_W'(0);
      tmo_cnt_s = TMO_W'(0);
      div_cnt_s = DIV_W'(0);
      parity_s  = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // Idle continuously holds the cleared load context.
          bit_cnt_s = BIT_W'(0);
          tmo_cnt_s = TMO_W'(0);
          div_cnt_s = DIV_W'(0);
          parity_s  = 1'b0;
          if (start) begin
            state_s = ST_LOAD;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_DONE, ST_ERROR: begin
          // Restart passes through the idle clear without spending a cycle there.
          if (start) begin
            state_s   = ST_LOAD;
            bit_cnt_s = BIT_W'(0);
            tmo_cnt_s = TMO_W'(0);
            div_cnt_s = DIV_W'(0);
            parity_s  = 1'b0;
          end else begin
            state_s = state_r;
          end
        end
        ST_LOAD: begin
          if (byte_valid && byte_ready_r) begin
            shreg_s    = byte_data;
            byte_bit_s = 3'd0;
            div_cnt_s  = DIV_W'(0);
            tmo_cnt_s  = TMO_W'(0);
            state_s    = ST_SHIFT_LO;
          end else if (tmo_cnt_r == TMO_W'(TIMEOUT - 1)) begin
            tmo_cnt_s = TMO_W'(0);
            state_s   = ST_ERROR;
          end else begin
            tmo_cnt_s = tmo_cnt_r + TMO_W'(1);
          end
        end
        ST_SHIFT_LO: begin
          if (div_last_s) begin
            parity_s  = parity_fold(tail_parity_r, ccff_tail);
            div_cnt_s = DIV_W'(0);
            state_s   = ST_SHIFT_HI;
          end else begin
            div_cnt_s = div_cnt_r + DIV_W'(1);
          end
        end
        ST_SHIFT_HI: begin
          if (div_last_s) begin
            div_cnt_s  = DIV_W'(0);
            bit_cnt_s  = bit_cnt_r + BIT_W'(1);
            shreg_s    = {1'b0, shreg_r[7:1]};
            byte_bit_s = byte_bit_r + 3'd1;
            if (bit_cnt_r == BIT_W'(CHAIN_LEN - 1)) begin
              fin_s   = 1'b0;
              state_s = ST_FINISH;
            end else if (byte_bit_r == 3'd7) begin
              tmo_cnt_s = TMO_W'(0);
              state_s   = ST_LOAD;
            end else begin
              state_s = ST_SHIFT_LO;
            end
          end else begin
            div_cnt_s = div_cnt_r + DIV_W'(1);
          end
        end
        ST_FINISH: begin
          if (fin_r) begin
            state_s = ST_DONE;
          end else begin
            fin_s = 1'b1;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      shreg_r    <= 8'h00;
      bit_cnt_r  <= BIT_W'(0);
      byte_bit_r <= 3'd0;
      div_cnt_r  <= DIV_W'(0);
      tmo_cnt_r  <= TMO_W'(0);
      fin_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      shreg_r    <= shreg_s;
      bit_cnt_r  <= bit_cnt_s;
      byte_bit_r <= byte_bit_s;
      div_cnt_r  <= div_cnt_s;
      tmo_cnt_r  <= tmo_cnt_s;
      fin_r      <= fin_s;
    end
  end

  // Output registers decoded from the next state so pins track the state exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_ready_r   <= 1'b0;
      prog_clk_r     <= 1'b0;
      ccff_head_r    <= 1'b0;
      fabric_reset_r <= 1'b1;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      error_r        <= 1'b0;
      tail_parity_r  <= 1'b0;
    end else begin
      byte_ready_r   <= (state_s == ST_LOAD);
      prog_clk_r     <= (state_s == ST_SHIFT_HI);
      ccff_head_r    <= ((state_s == ST_SHIFT_LO) || (state_s == ST_SHIFT_HI)) ? shreg_s[0] : 1'b0;
      fabric_reset_r <= (state_s != ST_DONE);
      busy_r         <= (state_s == ST_LOAD) || (state_s == ST_SHIFT_LO) ||
                        (state_s == ST_SHIFT_HI) || (state_s == ST_FINISH);
      done_r         <= (state_s == ST_DONE);
      error_r        <= (state_s == ST_ERROR);
      tail_parity_r  <= parity_s;
    end
  end

  assign byte_ready   = byte_ready_r;
  assign prog_clk     = prog_clk_r;
  assign ccff_head    = ccff_head_r;
  assign fabric_reset = fabric_reset_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign error        = error_r;
  assign tail_parity  = tail_parity_r;

endmodule

// File: tb/tb_ccff_loader.sv
// Testbench for ccff_loader with a 20-bit chain, CLK_DIV=2, TIMEOUT=16.
// Expected ccff_head bits are queued as bytes are handed over and popped at
// every prog_clk rising edge.
module tb_ccff_loader;

  localparam int CHAIN_LEN = 20;
  localparam int CLK_DIV   = 2;
  localparam int TIMEOUT   = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       byte_valid = 1'b0;
  logic       byte_ready;
  logic       prog_clk;
  logic       ccff_head;
  logic       ccff_tail = 1'b0;
  logic       fabric_reset;
  logic       busy;
  logic       done;
  logic       error;
  logic       tail_parity;

  int checks = 0;
  int errors = 0;
  int rises, transfers, idx, ready_cnt;
  logic exp_q[$];
  logic [7:0] bytes [3] = '{8'h5A, 8'hC3, 8'h0F};

  ccff_loader #(.CHAIN_LEN(CHAIN_LEN), .CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .prog_clk(prog_clk), .ccff_head(ccff_head), .ccff_tail(ccff_tail),
    .fabric_reset(fabric_reset), .busy(busy), .done(done), .error(error),
    .tail_parity(tail_parity)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // Drives one load; res: 0 done, 1 error, 2 abort raised, 3 budget expired, 4 parked in SHIFT_LO.
  task automatic run_load(input logic [19:0] pat, input int feed_bytes, input int abort_bit,
                          input int busy_start_bit, input int reset_bit, output int res);
    logic prev_pclk;
    logic exp_bit;
    bit   dup_done;
    bit   fin;
    int   pushed;
    rises = 0; transfers = 0; idx = 0; ready_cnt = 0; exp_q.delete();
    pushed = 0; prev_pclk = 1'b0; dup_done = 0; fin = 0; res = 3;
    @(negedge clk);
    start = 1'b1; ccff_tail = pat[0];
    byte_valid = (feed_bytes > 0); byte_data = bytes[0];
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL start_clears busy=%b done=%b error=%b required 1 0 0", busy, done, error);
    end
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      if (prog_clk === 1'b1 && prev_pclk === 1'b0) begin
        rises++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_rise rise=%0d with no expected bit queued", rises);
        end else begin
          exp_bit = exp_q.pop_front();
          if (ccff_head !== exp_bit) begin
            errors++;
            $display("FAIL head_bit bit=%0d got=%b required=%b", rises - 1, ccff_head, exp_bit);
          end
        end
      end
      prev_pclk = prog_clk;
      if (done === 1'b1 || error === 1'b1) begin
        res = (done === 1'b1) ? 0 : 1;
        fin = 1;
      end else if (abort_bit >= 0 && prog_clk === 1'b1 && rises == abort_bit + 1) begin
        abort = 1'b1;
        res = 2;
        fin = 1;
      end else if (reset_bit >= 0 && prog_clk === 1'b0 && rises == reset_bit) begin
        res = 4;
        fin = 1;
      end else begin
        start = 1'b0;
        if (!dup_done && busy_start_bit >= 0 && rises == busy_start_bit) begin
          start = 1'b1;
          dup_done = 1;
        end
        ccff_tail = (rises < 20) ? pat[rises] : 1'b0;
        byte_valid = (idx < feed_bytes) && (idx < 3);
        byte_data = (idx < 3) ? bytes[idx] : 8'h00;
        if (byte_valid && byte_ready === 1'b1 && !abort) begin
          transfers++;
          ready_cnt = 0;
          for (int b = 0; b < 8; b++) begin
            if (pushed < CHAIN_LEN) begin
              exp_q.push_back(byte_data[b]);
              pushed++;
            end
          end
          idx++;
        end else if (byte_ready === 1'b1) begin
          ready_cnt++;
        end
        @(negedge clk);
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL load_budget no terminal event within cycle budget");
    end
    start = 1'b0;
    byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({prog_clk, ccff_head, byte_ready, busy, done, error, fabric_reset, tail_parity} !== 8'b0000_0010) begin
      errors++;
      $display("FAIL reset_values got pc,hd,rdy,bsy,dn,er,fr,par=%b required 00000010",
               {prog_clk, ccff_head, byte_ready, busy, done, error, fabric_reset, tail_parity});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int res;
    run_load(20'h00000, 3, -1, -1, -1, res);
    checks++;
    if (res != 0 || rises != 20 || transfers != 3) begin
      errors++;
      $display("FAIL basic_load res=%0d rises=%0d transfers=%0d required 0 20 3", res, rises, transfers);
    end
    checks++;
    if (done !== 1'b1 || fabric_reset !== 1'b0 || busy !== 1'b0 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_status done=%b frst=%b busy=%b rdy=%b required 1 0 0 0",
               done, fabric_reset, busy, byte_ready);
    end
    checks++;
    if (exp_q.size() != 0 || tail_parity !== 1'b0) begin
      errors++;
      $display("FAIL basic_leftover queued=%0d parity=%b required 0 0", exp_q.size(), tail_parity);
    end
  endtask

  task automatic test_parity();
    logic [19:0] pats [3] = '{20'hFFFFF, 20'h55555, 20'h00080};
    int res;
    for (int p = 0; p < 3; p++) begin
      run_load(pats[p], 3, -1, -1, -1, res);
      checks++;
      if (res != 0 || rises != 20 || tail_parity !== (^pats[p])) begin
        errors++;
        $display("FAIL parity_%0d res=%0d rises=%0d parity=%b required 0 20 %b",
                 p, res, rises, tail_parity, ^pats[p]);
      end
    end
  endtask

  task automatic test_timeout();
    int res;
    run_load(20'h00000, 1, -1, -1, -1, res);
    checks++;
    if (res != 1 || ready_cnt != TIMEOUT || rises != 8 || transfers != 1) begin
      errors++;
      $display("FAIL timeout res=%0d ready_cycles=%0d rises=%0d transfers=%0d required 1 %0d 8 1",
               res, ready_cnt, rises, transfers, TIMEOUT);
    end
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || fabric_reset !== 1'b1 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL timeout_status err=%b done=%b busy=%b frst=%b rdy=%b required 1 0 0 1 0",
               error, done, busy, fabric_reset, byte_ready);
    end
  endtask

  task automatic test_abort();
    int res;
    run_load(20'h00000, 3, 5, -1, -1, res);
    @(negedge clk);
    checks++;
    if (res != 2 || prog_clk !== 1'b0 || done !== 1'b0 || busy !== 1'b0 ||
        byte_ready !== 1'b0 || fabric_reset !== 1'b1) begin
      errors++;
      $display("FAIL abort res=%0d pc=%b done=%b busy=%b rdy=%b frst=%b required 2 0 0 0 0 1",
               res, prog_clk, done, busy, byte_ready, fabric_reset);
    end
    abort = 1'b0;
    run_load(20'h00000, 3, -1, -1, -1, res);
    checks++;
    if (res != 0 || rises != 20 || transfers != 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_reload res=%0d rises=%0d transfers=%0d required 0 20 3", res, rises, transfers);
    end
  endtask

  task automatic test_back_to_back();
    int res;
    run_load(20'h00000, 3, -1, 10, -1, res);
    checks++;
    if (res != 0 || rises != 20 || transfers != 3) begin
      errors++;
      $display("FAIL start_busy res=%0d rises=%0d transfers=%0d required 0 20 3", res, rises, transfers);
    end
    run_load(20'h00001, 3, -1, -1, -1, res);
    checks++;
    if (res != 0 || rises != 20 || done !== 1'b1 || tail_parity !== 1'b1) begin
      errors++;
      $display("FAIL restart_done res=%0d rises=%0d done=%b parity=%b required 0 20 1 1",
               res, rises, done, tail_parity);
    end
  endtask

  task automatic test_async_reset();
    int res;
    run_load(20'h00000, 3, -1, -1, 3, res);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (res != 4 || {prog_clk, ccff_head, byte_ready, busy, done, error, fabric_reset, tail_parity} !== 8'b0000_0010) begin
      errors++;
      $display("FAIL async_reset res=%0d pc,hd,rdy,bsy,dn,er,fr,par=%b required 4 00000010", res,
               {prog_clk, ccff_head, byte_ready, busy, done, error, fabric_reset, tail_parity});
    end
    @(negedge clk);
    reset = 1'b0;
    run_load(20'h00000, 3, -1, -1, -1, res);
    checks++;
    if (res != 0 || rises != 20 || transfers != 3) begin
      errors++;
      $display("FAIL after_reset res=%0d rises=%0d transfers=%0d required 0 20 3", res, rises, transfers);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
